// File: rtl/ntt_pkg.sv
// Shared NTT constants and modular helpers for coefficients already in [0,q-1].
package ntt_pkg;

    localparam int unsigned W         = 12;
    localparam int unsigned Q         = 3329;
    localparam int unsigned BARRETT_K = 2 * W;
    localparam int unsigned BARRETT_R = (32'd1 << BARRETT_K) / Q;
    localparam int unsigned INV2      = (Q + 1) / 2;

    function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                            input int unsigned q);
        int unsigned s;
        s = a + b;
        return (s >= q) ? s - q : s;
    endfunction

    function automatic int unsigned mod_sub(input int unsigned a, input int unsigned b,
                                            input int unsigned q);
        return (a >= b) ? a - b : a + q - b;
    endfunction

    // Multiply by 2^-1 mod q: odd values borrow one q so the shift stays exact.
    function automatic int unsigned mod_half(input int unsigned y, input int unsigned q);
        return y[0] ? (y + q) >> 1 : y >> 1;
    endfunction

endpackage

// File: rtl/mod_mult_barrett.sv
// Two-stage modular multiplier: registered product, then registered Barrett reduction.
module mod_mult_barrett #(
    parameter int unsigned W     = 12,
    parameter int unsigned Q     = 3329,
    parameter int unsigned SideW = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic [SideW-1:0] side_i,
    output logic             valid_o,
    output logic [W-1:0]     t_o,
    output logic [SideW-1:0] side_o
);
    import ntt_pkg::BARRETT_K;

    localparam int unsigned     K     = 2 * W;
    localparam longint unsigned RFull = (64'd1 << K) / 64'(Q);
    localparam logic [K-1:0]    BarR  = K'(RFull);
    localparam logic [K-1:0]    QK    = K'(Q);

    logic             v1_q, v1_d, v2_q, v2_d;
    logic [K-1:0]     p1_q, p1_d;
    logic [W-1:0]     t2_q, t2_d;
    logic [SideW-1:0] s1_q, s1_d, s2_q, s2_d;

    logic [2*K-1:0]   pr;
    logic [K-1:0]     qe, qq, t;

    always_comb begin
        pr = {{K{1'b0}}, p1_q} * {{K{1'b0}}, BarR};
        qe = K'(pr >> K);
        qq = qe * QK;
        // Estimate qe undershoots by at most two, so t < 3Q before correction.
        t  = p1_q - qq;
        if (t >= QK) t = t - QK;
        if (t >= QK) t = t - QK;

        v1_d = v1_q;
        p1_d = p1_q;
        s1_d = s1_q;
        v2_d = v2_q;
        t2_d = t2_q;
        s2_d = s2_q;
        if (en_i) begin
            v1_d = valid_i;
            p1_d = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
            s1_d = side_i;
            v2_d = v1_q;
            t2_d = t[W-1:0];
            s2_d = s1_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q <= 1'b0;
            p1_q <= '0;
            s1_q <= '0;
            v2_q <= 1'b0;
            t2_q <= '0;
            s2_q <= '0;
        end else begin
            v1_q <= v1_d;
            p1_q <= p1_d;
            s1_q <= s1_d;
            v2_q <= v2_d;
            t2_q <= t2_d;
            s2_q <= s2_d;
        end
    end

    assign valid_o = v2_q;
    assign t_o     = t2_q;
    assign side_o  = s2_q;

    if (BARRETT_K == 0) begin : g_never
    end

endmodule

// File: rtl/intt_ct_butterfly.sv
// Cooley-Tukey inverse-NTT butterfly: x1 = u + tw*v, x2 = u - tw*v (mod Q), optional halving.
module intt_ct_butterfly #(
    parameter int unsigned W = ntt_pkg::W,
    parameter int unsigned Q = ntt_pkg::Q
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] u_inp,
    input  logic [W-1:0] v_inp,
    input  logic [W-1:0] tw_inp,
    input  logic         scale_half,
    output logic [W-1:0] x1_out,
    output logic [W-1:0] x2_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         err
);
    import ntt_pkg::mod_add;
    import ntt_pkg::mod_sub;
    import ntt_pkg::mod_half;

    logic         en, accept, range_bad;
    logic         v2, sh2;
    logic [W-1:0] u2, t2;
    int unsigned  a, b;

    logic         out_valid_q, out_valid_d, err_q, err_d;
    logic [W-1:0] x1_q, x1_d, x2_q, x2_d;

    // Single global advance: the whole pipe freezes only while the output is blocked.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    mod_mult_barrett #(
        .W     (W),
        .Q     (Q),
        .SideW (W + 1)
    ) u_mult (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .en_i    (en),
        .valid_i (in_valid),
        .a_i     (v_inp),
        .b_i     (tw_inp),
        .side_i  ({scale_half, u_inp}),
        .valid_o (v2),
        .t_o     (t2),
        .side_o  ({sh2, u2})
    );

    always_comb begin
        range_bad = (32'(u_inp) >= Q) || (32'(v_inp) >= Q) || (32'(tw_inp) >= Q);

        a = mod_add(32'(u2), 32'(t2), Q);
        b = mod_sub(32'(u2), 32'(t2), Q);
        if (sh2) begin
            a = mod_half(a, Q);
            b = mod_half(b, Q);
        end

        out_valid_d = out_valid_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        if (en) begin
            out_valid_d = v2;
            if (v2) begin
                x1_d = W'(a);
                x2_d = W'(b);
            end
        end
        err_d = err_q || (accept && range_bad);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            x1_q        <= '0;
            x2_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign x1_out    = x1_q;
    assign x2_out    = x2_q;
    assign err       = err_q;

endmodule

// File: tb/tb_intt_ct_butterfly.sv
// Self-checking bench for intt_ct_butterfly: directed table, stall stream, random traffic, resets.
module tb_intt_ct_butterfly;

    localparam int unsigned W    = 12;
    localparam int unsigned Q    = 3329;
    localparam int unsigned INV2 = (Q + 1) / 2;

    logic         clock = 1'b0;
    logic         reset_n, in_valid, in_ready, scale_half, out_valid, out_ready, err;
    logic [W-1:0] u_inp, v_inp, tw_inp, x1_out, x2_out;

    always #5 clock = ~clock;

    intt_ct_butterfly #(.W(W), .Q(Q)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .u_inp      (u_inp),
        .v_inp      (v_inp),
        .tw_inp     (tw_inp),
        .scale_half (scale_half),
        .x1_out     (x1_out),
        .x2_out     (x2_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err        (err)
    );

    typedef struct {
        int unsigned u, v, tw;
        bit          sh;
        int unsigned x1, x2;
    } vec_t;

    typedef struct {
        int unsigned x1, x2;
        bit          dc;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;
    bit   rnd_done;

    function automatic exp_t model(input int unsigned u, input int unsigned v,
                                   input int unsigned tw, input bit sh);
        exp_t            e;
        longint unsigned m, s, d;
        m = (64'(v) * 64'(tw)) % 64'(Q);
        s = (64'(u) + m) % 64'(Q);
        d = (64'(u) + 64'(Q) - m) % 64'(Q);
        if (sh) begin
            s = (s * 64'(INV2)) % 64'(Q);
            d = (d * 64'(INV2)) % 64'(Q);
        end
        e.x1 = 32'(s);
        e.x2 = 32'(d);
        e.dc = (u >= Q) || (v >= Q) || (tw >= Q);
        return e;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Scoreboard: record expectations on input transfers, compare on output transfers.
    always @(negedge clock) begin
        if (mon_en && reset_n) begin
            if (in_valid && in_ready)
                sb.push_back(model(32'(u_inp), 32'(v_inp), 32'(tw_inp), scale_half));
            if (out_valid && !out_ready)
                check("stall_in_ready", 32'(in_ready), 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (!e.dc) begin
                        check("stream_x1", 32'(x1_out), e.x1);
                        check("stream_x2", 32'(x2_out), e.x2);
                    end
                end
            end
        end
    end

    // Caller sits at posedge+#1; returns at posedge+#1 right after the transfer edge.
    task automatic send(input int unsigned u, input int unsigned v, input int unsigned tw,
                        input bit sh);
        int g;
        u_inp      = W'(u);
        v_inp      = W'(v);
        tw_inp     = W'(tw);
        scale_half = sh;
        in_valid   = 1'b1;
        @(negedge clock);
        g = 0;
        while (!in_ready && g < 200) begin
            @(negedge clock);
            g++;
        end
        if (!in_ready) fail_now("send_timeout");
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 500) begin
            @(posedge clock);
            g++;
        end
        #1;
        if (sb.size() != 0) fail_now("drain_timeout");
    endtask

    vec_t tbl[7];
    int   lat, seen;

    initial begin
        tbl = '{
            '{u:5,    v:7,    tw:1,    sh:1'b0, x1:12,   x2:3327},
            '{u:0,    v:3328, tw:3328, sh:1'b0, x1:1,    x2:3328},
            '{u:3328, v:1,    tw:1,    sh:1'b0, x1:0,    x2:3327},
            '{u:1,    v:0,    tw:17,   sh:1'b1, x1:1665, x2:1665},
            '{u:4,    v:2,    tw:1,    sh:1'b1, x1:3,    x2:1},
            '{u:100,  v:3000, tw:3000, sh:1'b0, x1:1813, x2:1716},
            '{u:100,  v:3000, tw:3000, sh:1'b1, x1:2571, x2:858}
        };

        reset_n    = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        u_inp      = '0;
        v_inp      = '0;
        tw_inp     = '0;
        scale_half = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_x1", 32'(x1_out), 0);
        check("rst_x2", 32'(x2_out), 0);
        check("rst_err", 32'(err), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Directed table: latency, values and single-cycle out_valid.
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].u, tbl[i].v, tbl[i].tw, tbl[i].sh);
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(posedge clock);
                #1;
                lat++;
            end
            check("dir_latency", lat, 3);
            check("dir_x1", 32'(x1_out), tbl[i].x1);
            check("dir_x2", 32'(x2_out), tbl[i].x2);
            @(posedge clock);
            #1;
            check("dir_valid_pulse", 32'(out_valid), 0);
        end

        // Eight back-to-back butterflies with the sink stalled for five cycles.
        sb.delete();
        mon_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send($urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
                         $urandom_range(0, Q - 1), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (3) @(posedge clock);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic with random input gaps and output back-pressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        @(posedge clock);
                        #1;
                    end
                    send($urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
                         $urandom_range(0, Q - 1), 1'($urandom_range(0, 1)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clock);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Sticky range error, cleared only by reset.
        send(3329, 0, 0, 1'b0);
        check("err_set", 32'(err), 1);
        drain();
        send(7, 8, 9, 1'b0);
        drain();
        repeat (3) @(posedge clock);
        #1;
        check("err_sticky", 32'(err), 1);
        #2;
        reset_n = 1'b0;
        #2;
        check("err_cleared", 32'(err), 0);
        reset_n = 1'b1;
        sb.delete();
        @(posedge clock);
        #1;

        // Asynchronous reset with a full, stalled pipeline.
        mon_en    = 1'b0;
        out_ready = 1'b0;
        send(11, 22, 33, 1'b0);
        send(44, 55, 66, 1'b1);
        send(77, 88, 99, 1'b0);
        check("full_out_valid", 32'(out_valid), 1);
        check("full_in_ready", 32'(in_ready), 0);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_x1", 32'(x1_out), 0);
        check("async_rst_x2", 32'(x2_out), 0);
        #3;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            if (out_valid) seen++;
        end
        check("no_output_after_reset", seen, 0);
        sb.delete();
        mon_en = 1'b1;
        send(1234, 2345, 3210, 1'b1);
        drain();
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/intt_ct_butterfly.md
Name: intt_ct_butterfly

Overview:
- Inverse-NTT butterfly, Cooley-Tukey / decimation-in-time form.
- Complements the forward Gentleman-Sande butterfly unit.
- Computes x1 = (u + tw·v) mod Q and x2 = (u − tw·v) mod Q, with optional multiply-by-2⁻¹ for INTT scaling.
- Fully pipelined with a valid/ready handshake on both sides; sits between coefficient memory and the INTT stage controller.

Parameters:
- W, 12, coefficient and twiddle width; Q < 2^W.
- Q, 3329, prime modulus; must be odd.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  u/v/tw/scale_half valid
- in_ready  out  1  unit accepts input this cycle
- u_inp  in  W  top operand, expected in [0,Q-1]
- v_inp  in  W  bottom operand, expected in [0,Q-1]
- tw_inp  in  W  twiddle (inverse root power), expected in [0,Q-1]
- scale_half  in  1  multiply both results by (Q+1)/2 mod Q
- x1_out  out  W  (u + tw·v) mod Q, optionally halved
- x2_out  out  W  (u − tw·v) mod Q, optionally halved
- out_valid  out  1  x1/x2 valid
- out_ready  in  1  downstream accepts output
- err  out  1  sticky range error

Behaviour:
- Reset (async, reset_n=0): all stage valids = 0, out_valid = 0, x1_out = x2_out = 0, err = 0. in_ready is combinational and therefore reads 1 during reset.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Pipeline: three stages, one global advance enable en = !out_valid || out_ready. in_ready = en.
  - S1: register u, scale_half, and p = v·tw (2W-bit unsigned product).
  - S2: Barrett reduction of p to t = p mod Q in [0,Q-1]. Carry u and scale_half forward.
  - S3: compute a = u + t and b = u − t, each brought into [0,Q-1] by one conditional ±Q.
    - If scale_half is set: y → y/2 when y is even, (y+Q)/2 when y is odd.
    - Register the results to x1_out and x2_out.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput is 1 butterfly per cycle.
- Stall: while out_valid && !out_ready, every stage register and output holds and in_ready = 0. Results are never dropped, duplicated, or reordered.
- Bubbles: stage valids propagate on en; an empty stage with en=1 simply shifts.
- Barrett arithmetic:
  - k = 2W, R = floor(2^k / Q); for Q=3329, R = 5039.
  - qe = (p·R) >> k; t = p − qe·Q, followed by at most two conditional subtractions of Q.
  - Result must equal p mod Q for every p < Q².
- Range check: on an accepted input where u ≥ Q, v ≥ Q, or tw ≥ Q, err is set on the next edge and stays set until reset. The data is still processed; its result value is unspecified but must be a W-bit value with out_valid asserted normally.
- Simultaneous events: an output transfer and an input transfer in the same cycle are legal; the pipeline shifts by one.
- Reset mid-operation: in-flight butterflies are discarded; no out_valid appears after release until new inputs are accepted.
- out_valid and the data outputs change only on the clock edge, never combinationally from out_ready.

Decomposition:
- ntt_pkg holds the constants: Q, W, BARRETT_K = 2W, BARRETT_R = floor(2^(2W)/Q), INV2 = (Q+1)/2, plus the modular add/sub/halve functions.
- One sub-module, mod_mult_barrett: registered product stage plus registered reduction stage (S1–S2), with valid/enable pass-through.
- The butterfly top holds the S3 add/sub/halve, the handshake, and err.

Test Plan:
- u=5, v=7, tw=1, scale_half=0, out_ready=1 → after 3 cycles x1=12, x2=3327, out_valid for 1 cycle.
- u=0, v=3328, tw=3328 → x1=1, x2=3328 (since (−1)·(−1)=1). u=3328, v=1, tw=1 → x1=0, x2=3327 (wrap-around).
- u=1, v=0, tw=17, scale_half=1 → x1=x2=1665. u=4, v=2, tw=1, scale_half=1 → x1=3, x2=1.
- Stream 8 butterflies back-to-back with out_ready=0 for cycles 4–8:
  - in_ready=0 during the stall.
  - All 8 results later emerge in order and match the golden model (random u,v,tw < Q, 10k vectors, scale_half random).
- u=3329, v=0, tw=0 accepted → err=1 from the next cycle and stays 1; pulse reset_n low → err=0.
- Pipeline full with out_ready=0, assert reset_n=0 asynchronously mid-cycle → out_valid=0 and x1_out=x2_out=0 immediately; after release there is no output until a new input transfer.
